// File: rtl/irq_ctrl_if.sv
// CPU I/O-port bus as seen by the interrupt controller.
// The master side is the CPU; the slave side is irq_ctrl.
interface irq_ctrl_if #(
    parameter int ADDR_W = 22
);
    logic [ADDR_W-1:0] address_bus;
    logic [7:0]        data_bus_out;
    logic              rd;
    logic              wr;
    logic              mem_io;
    logic [7:0]        reg_data;
    logic              reg_oe;

    modport master (
        output address_bus, data_bus_out, rd, wr, mem_io,
        input  reg_data, reg_oe
    );

    modport slave (
        input  address_bus, data_bus_out, rd, wr, mem_io,
        output reg_data, reg_oe
    );
endinterface

// File: rtl/irq_ctrl.sv
// 8-input interrupt controller: synchronises sources, latches edge/level
// pending bits, masks them toward the CPU, and exposes four I/O-port registers.
module irq_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         ADDR_W    = 22
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] irq_src,
    irq_ctrl_if.slave  bus,
    output logic [7:0] pins_irq_req
);
    typedef enum logic [1:0] {
        OFF_PENDING = 2'd0,
        OFF_MASK    = 2'd1,
        OFF_MODE    = 2'd2,
        OFF_HIGHEST = 2'd3
    } reg_off_e;

    logic [7:0] s1, s2, s3;
    logic [7:0] pending, mask, mode;
    logic       wr_q;

    logic       hit, wr_pulse, rd_sel;
    reg_off_e   off;
    logic [7:0] active, rise, clr, pending_next, highest, rd_value;

    // Upper address bits take no part in decode.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address_bus[ADDR_W-1:8];

    assign hit      = !bus.mem_io && (bus.address_bus[7:2] == BASE_ADDR[7:2]);
    assign off      = reg_off_e'(bus.address_bus[1:0]);
    assign wr_pulse = hit && bus.wr && !wr_q;
    assign rd_sel   = hit && bus.rd && !bus.wr;

    assign active = pending & mask;
    assign rise   = s2 & ~s3;
    assign clr    = (wr_pulse && off == OFF_PENDING) ? bus.data_bus_out : 8'h00;

    // Edge bits: set beats clear in the same cycle. Level bits track s2.
    assign pending_next = (mode & ((pending & ~clr) | rise)) | (~mode & s2);

    always_comb begin
        highest = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) highest = {1'b1, 4'b0000, i[2:0]};
        end
    end

    always_comb begin
        rd_value = 8'h00;
        unique case (off)
            OFF_PENDING: rd_value = pending;
            OFF_MASK:    rd_value = mask;
            OFF_MODE:    rd_value = mode;
            OFF_HIGHEST: rd_value = highest;
            default:     rd_value = 8'h00;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others, which is what makes the s1/s2/s3 chain a pipeline.
    always_ff @(posedge clk) begin
        if (arst) begin
            s1           <= 8'h00;
            s2           <= 8'h00;
            s3           <= 8'h00;
            pending      <= 8'h00;
            mask         <= 8'h00;
            mode         <= 8'hFF;
            wr_q         <= 1'b0;
            pins_irq_req <= 8'h00;
            bus.reg_oe   <= 1'b0;
            bus.reg_data <= 8'h00;
        end else begin
            s1           <= irq_src;
            s2           <= s1;
            s3           <= s2;
            wr_q         <= bus.wr;
            pending      <= pending_next;
            pins_irq_req <= active;
            if (wr_pulse && off == OFF_MASK) mask <= bus.data_bus_out;
            if (wr_pulse && off == OFF_MODE) mode <= bus.data_bus_out;
            bus.reg_oe   <= rd_sel;
            bus.reg_data <= rd_sel ? rd_value : 8'h00;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: cycle-level reference model compared every
// cycle, plus hand-computed expectations for the documented scenarios.
module tb_irq_ctrl;
    localparam int ADDR_W = 22;

    logic       clk     = 1'b0;
    logic       arst    = 1'b1;
    logic [7:0] irq_src = 8'h00;
    logic [7:0] pins_irq_req;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    irq_ctrl #(.BASE_ADDR(8'hE0), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .arst         (arst),
        .irq_src      (irq_src),
        .bus          (bus),
        .pins_irq_req (pins_irq_req)
    );

    always #5 clk = ~clk;

    // Reference state: registers plus the last three sampled source values.
    typedef struct packed {
        logic [7:0] pend, mask, mode, pins, data;
        logic [7:0] h0, h1, h2;
        logic       oe, wr_prev, valid;
    } model_t;

    model_t m = '0;

    function automatic model_t step(model_t c, logic rst, logic [7:0] src,
                                    logic [ADDR_W-1:0] a, logic [7:0] d,
                                    logic rd, logic wr, logic mem_io);
        model_t     n = c;
        logic [7:0] lo, act, rv, clr;
        logic       hit, first;
        if (rst) begin
            n       = '0;
            n.mode  = 8'hFF;
            n.valid = 1'b1;
            return n;
        end
        lo    = a[7:0];
        hit   = !mem_io && lo >= 8'hE0 && lo <= 8'hE3;
        first = wr && !c.wr_prev;
        act   = c.pend & c.mask;
        case (lo[1:0])
            2'd0:    rv = c.pend;
            2'd1:    rv = c.mask;
            2'd2:    rv = c.mode;
            default: begin
                rv = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (act[i] && rv == 8'h00) rv = 8'h80 + 8'(i);
                end
            end
        endcase
        clr = (hit && first && lo[1:0] == 2'd0) ? d : 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (c.mode[i]) n.pend[i] = (c.pend[i] && !clr[i]) || (c.h1[i] && !c.h2[i]);
            else           n.pend[i] = c.h1[i];
        end
        n.pins = act;
        n.oe   = hit && rd && !wr;
        n.data = n.oe ? rv : 8'h00;
        if (hit && first && lo[1:0] == 2'd1) n.mask = d;
        if (hit && first && lo[1:0] == 2'd2) n.mode = d;
        n.wr_prev = wr;
        n.h2 = c.h1;
        n.h1 = c.h0;
        n.h0 = src;
        return n;
    endfunction

    always @(posedge clk)
        m <= step(m, arst, irq_src, bus.address_bus, bus.data_bus_out,
                  bus.rd, bus.wr, bus.mem_io);

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m.valid) begin
            check("model pins_irq_req", pins_irq_req, m.pins);
            check("model reg_oe", {7'b0, bus.reg_oe}, {7'b0, m.oe});
            check("model reg_data", bus.reg_data, m.data);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(logic [ADDR_W-1:0] a, logic [7:0] d, logic r, logic w, logic mio);
        bus.address_bus  = a;
        bus.data_bus_out = d;
        bus.rd           = r;
        bus.wr           = w;
        bus.mem_io       = mio;
    endtask

    task automatic idle();
        drive('0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr_reg(logic [1:0] off, logic [7:0] d);
        drive(ADDR_W'({6'b111000, off}), d, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
    endtask

    task automatic rd_reg(string name, logic [1:0] off, logic [7:0] exp);
        drive(ADDR_W'({6'b111000, off}), 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        check({name, " oe"}, {7'b0, bus.reg_oe}, 8'h01);
        check(name, bus.reg_data, exp);
        idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tick(3);
        arst = 1'b0;
        tick(3);
        check("reset pins", pins_irq_req, 8'h00);
        check("reset reg_oe", {7'b0, bus.reg_oe}, 8'h00);
        rd_reg("reset MASK", 2'd1, 8'h00);
        rd_reg("reset MODE", 2'd2, 8'hFF);
        rd_reg("reset PENDING", 2'd0, 8'h00);

        wr_reg(2'd1, 8'h05);
        rd_reg("MASK write", 2'd1, 8'h05);

        // Source 2 rise: PENDING two edges after sampling, pins one later.
        irq_src = 8'h04;
        tick(2);
        check("pending before latency", dut.pending, 8'h00);
        tick();
        check("pending at c+2", dut.pending, 8'h04);
        check("pins at c+2", pins_irq_req, 8'h00);
        tick();
        check("pins at c+3", pins_irq_req, 8'h04);
        rd_reg("HIGHEST 04", 2'd3, 8'h82);

        wr_reg(2'd1, 8'hFF);
        irq_src = 8'h0C;
        tick(3);
        check("pending 0C", dut.pending, 8'h0C);
        tick();
        check("pins 0C", pins_irq_req, 8'h0C);
        rd_reg("HIGHEST 0C", 2'd3, 8'h82);

        // Write-1-to-clear bit 2.
        drive(ADDR_W'(8'hE0), 8'h04, 1'b0, 1'b1, 1'b0);
        tick();
        check("w1c pending", dut.pending, 8'h08);
        idle();
        tick();
        check("w1c pins", pins_irq_req, 8'h08);

        // Long strobe whose first cycle collides with a new rise on bit 3.
        irq_src = 8'h04;
        tick(3);
        irq_src = 8'h0C;
        tick(2);
        drive(ADDR_W'(8'hE0), 8'h08, 1'b0, 1'b1, 1'b0);
        tick();
        check("set wins", dut.pending, 8'h08);
        tick(3);
        idle();
        check("long strobe", dut.pending, 8'h08);
        tick();
        check("long strobe pins", pins_irq_req, 8'h08);

        // Bit 0 in level mode.
        wr_reg(2'd2, 8'hFE);
        irq_src = 8'h0D;
        tick(3);
        check("level set", dut.pending, 8'h09);
        wr_reg(2'd0, 8'h01);
        check("level ignores w1c", dut.pending, 8'h09);
        irq_src = 8'h0C;
        tick(2);
        check("level drop pending", dut.pending, 8'h09);
        tick();
        check("level dropped", dut.pending, 8'h08);

        // Memory cycles never hit; upper address bits ignored on I/O cycles.
        wr_reg(2'd1, 8'h0F);
        drive(22'h0000E1, 8'hFF, 1'b0, 1'b1, 1'b1);
        tick();
        check("mem wr reg_oe", {7'b0, bus.reg_oe}, 8'h00);
        idle();
        tick();
        drive(22'h0000E1, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        check("mem rd reg_oe", {7'b0, bus.reg_oe}, 8'h00);
        check("mem rd reg_data", bus.reg_data, 8'h00);
        idle();
        tick();
        drive(22'h3FFFE1, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        check("high bits ignored", bus.reg_data, 8'h0F);
        idle();
        tick();

        // rd and wr together: write happens, read suppressed.
        drive(ADDR_W'(8'hE1), 8'h33, 1'b1, 1'b1, 1'b0);
        tick();
        check("rd+wr reg_oe", {7'b0, bus.reg_oe}, 8'h00);
        idle();
        tick();
        rd_reg("rd+wr MASK", 2'd1, 8'h33);

        // Reset in the middle of a read.
        wr_reg(2'd1, 8'hFF);
        drive(ADDR_W'(8'hE3), 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre-reset HIGHEST", bus.reg_data, 8'h83);
        arst = 1'b1;
        tick();
        check("reset reg_oe", {7'b0, bus.reg_oe}, 8'h00);
        check("reset pins mid-read", pins_irq_req, 8'h00);
        arst = 1'b0;
        idle();
        tick(4);
        check("held source one edge", dut.pending, 8'h0C);
        check("post-reset pins", pins_irq_req, 8'h00);
        rd_reg("post-reset MODE", 2'd2, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
